// File: rtl/sram_arb_pkg.sv
// Shared types and constants for the two-requester syncRAM arbiter.
package sram_arb_pkg;

    // Default RAM geometry (matches the existing syncRAM)
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ADDR_W = 8;

    // Requester identifiers, also used as grant/response ids
    localparam logic REQ_A = 1'b0;
    localparam logic REQ_B = 1'b1;

    // Command presented by a requester
    typedef struct packed {
        logic                  we;
        logic [DEF_ADDR_W-1:0] addr;
        logic [DEF_DATA_W-1:0] wdata;
    } cmd_t;

    // One slot of the read-return tracking pipeline
    typedef struct packed {
        logic vld;
        logic rd;
        logic id;
    } trk_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter: grants at most one requester per cycle and
// hands priority to the other requester after every grant.
module rr_arbiter2
    import sram_arb_pkg::*;
(
    input  logic       Clk,
    input  logic       Rst,
    input  logic [1:0] req,
    output logic [1:0] gnt
);

    // Requester that wins when both are asking
    logic r_ptr;

    // Combinational grant; nothing is granted while reset is held
    always_comb begin
        // NOTE: default first so every path assigns gnt and no latch is inferred.
        gnt = 2'b00;
        if (!Rst) begin
            if (req == 2'b11) begin
                gnt = (r_ptr == REQ_B) ? 2'b10 : 2'b01;
            end else begin
                gnt = req;
            end
        end
    end

    // Priority pointer moves to the requester that was not just served
    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments for all state so every flop updates from pre-edge values.
        if (Rst) begin
            r_ptr <= REQ_A;
        end else if (gnt[0]) begin
            r_ptr <= REQ_B;
        end else if (gnt[1]) begin
            r_ptr <= REQ_A;
        end
    end

endmodule

// File: rtl/sram_arbiter.sv
// Arbiter/sequencer in front of syncRAM: round-robin grant between A and B,
// registered RAM strobes, and fixed two-cycle read return to the originator.
module sram_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int ADDR_W = DEF_ADDR_W
) (
    input  logic              Clk,
    input  logic              Rst,

    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,

    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,

    output logic              ram_CS,
    output logic              ram_WE,
    output logic              ram_RD,
    output logic [ADDR_W-1:0] ram_Addr,
    output logic [DATA_W-1:0] ram_dataIn,
    input  logic [DATA_W-1:0] ram_dataOut
);

    logic [1:0] w_gnt;
    logic       w_any;
    logic       w_id;
    cmd_t       w_cmd;

    logic              r_cs;
    logic              r_we;
    logic              r_rd;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_din;

    // r_trk0 describes the command on the RAM pins this cycle,
    // r_trk1 the one whose read data is on ram_dataOut this cycle.
    trk_t r_trk0;
    trk_t r_trk1;

    logic w_ret_a;
    logic w_ret_b;

    rr_arbiter2 u_rr (
        .Clk (Clk),
        .Rst (Rst),
        .req ({b_valid, a_valid}),
        .gnt (w_gnt)
    );

    assign a_ready = w_gnt[0];
    assign b_ready = w_gnt[1];
    assign w_any   = |w_gnt;
    assign w_id    = w_gnt[1] ? REQ_B : REQ_A;

    // Select the granted requester's command
    always_comb begin
        w_cmd = '{we: a_we, addr: a_addr, wdata: a_wdata};
        if (w_gnt[1]) begin
            w_cmd = '{we: b_we, addr: b_addr, wdata: b_wdata};
        end
    end

    // Issue register: strobes pulse for one cycle per grant, address/data hold when idle
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_cs   <= 1'b0;
            r_we   <= 1'b0;
            r_rd   <= 1'b0;
            r_addr <= '0;
            r_din  <= '0;
        end else begin
            r_cs <= w_any;
            r_we <= w_any & w_cmd.we;
            r_rd <= w_any & ~w_cmd.we;
            if (w_any) begin
                r_addr <= w_cmd.addr;
                r_din  <= w_cmd.wdata;
            end
        end
    end

    // Response tracking shift; reset drops anything in flight
    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_trk0 <= '0;
            r_trk1 <= '0;
        end else begin
            r_trk0 <= '{vld: w_any, rd: ~w_cmd.we, id: w_id};
            r_trk1 <= r_trk0;
        end
    end

    assign ram_CS     = r_cs;
    assign ram_WE     = r_we;
    assign ram_RD     = r_rd;
    assign ram_Addr   = r_addr;
    assign ram_dataIn = r_din;

    // RAM output is already registered by syncRAM, so it is routed straight through
    assign w_ret_a  = r_trk1.vld & r_trk1.rd & (r_trk1.id == REQ_A);
    assign w_ret_b  = r_trk1.vld & r_trk1.rd & (r_trk1.id == REQ_B);
    assign a_rvalid = w_ret_a;
    assign b_rvalid = w_ret_b;
    assign a_rdata  = w_ret_a ? ram_dataOut : '0;
    assign b_rdata  = w_ret_b ? ram_dataOut : '0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Self-checking bench for sram_arbiter with a behavioural syncRAM beside it.
module tb_sram_arbiter;

    logic       Clk = 1'b0;
    logic       Rst;
    logic       a_valid, a_we, b_valid, b_we;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_ready, b_ready, a_rvalid, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       ram_CS, ram_WE, ram_RD;
    logic [7:0] ram_Addr, ram_dataIn, ram_dataOut;

    typedef struct {
        logic       id;
        logic [7:0] data;
        int         acc;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mem[256];
    logic [7:0] shadow[256];
    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    bit         mon_en = 1'b0;
    logic       exp_cs = 1'b0;
    logic       exp_we = 1'b0;
    logic [7:0] exp_addr = '0;
    logic [7:0] exp_din = '0;

    sram_arbiter dut (
        .Clk(Clk), .Rst(Rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_we(a_we), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_we(b_we), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .ram_CS(ram_CS), .ram_WE(ram_WE), .ram_RD(ram_RD), .ram_Addr(ram_Addr),
        .ram_dataIn(ram_dataIn), .ram_dataOut(ram_dataOut)
    );

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc++;

    // Behavioural syncRAM: write on CS&WE, registered read on CS&RD
    always @(posedge Clk) begin
        if (ram_CS && ram_WE) mem[ram_Addr] <= ram_dataIn;
        if (ram_CS && ram_RD) ram_dataOut <= mem[ram_Addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: RAM strobes vs. last cycle's acceptance, read returns vs. scoreboard
    always @(negedge Clk) begin
        if (mon_en) begin
            if (exp_cs) begin
                check("ram_cs", ram_CS, 1);
                check("ram_we", ram_WE, exp_we);
                check("ram_rd", ram_RD, !exp_we);
                check("ram_addr", ram_Addr, exp_addr);
                if (exp_we) check("ram_din", ram_dataIn, exp_din);
            end else begin
                check("ram_strobes_idle", {ram_CS, ram_WE, ram_RD}, 0);
            end
            check("rvalid_excl", a_rvalid & b_rvalid, 0);
            if (a_rvalid || b_rvalid) begin
                if (q.size() == 0) begin
                    check("rvalid_unexpected", {a_rvalid, b_rvalid}, 2'b00);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("ret_id", b_rvalid, e.id);
                    check("ret_data", b_rvalid ? b_rdata : a_rdata, e.data);
                    check("ret_latency", cyc - e.acc, 2);
                end
            end
            exp_cs = 1'b0;
            if (a_valid && a_ready) begin
                exp_cs = 1'b1; exp_we = a_we; exp_addr = a_addr; exp_din = a_wdata;
                if (a_we) shadow[a_addr] = a_wdata;
                else q.push_back('{id: 1'b0, data: shadow[a_addr], acc: cyc});
            end else if (b_valid && b_ready) begin
                exp_cs = 1'b1; exp_we = b_we; exp_addr = b_addr; exp_din = b_wdata;
                if (b_we) shadow[b_addr] = b_wdata;
                else q.push_back('{id: 1'b1, data: shadow[b_addr], acc: cyc});
            end
        end
    end

    // One cycle of stimulus; readiness checked mid-cycle
    task automatic drv(input logic av, input logic aw, input logic [7:0] aa, input logic [7:0] ad,
                       input logic bv, input logic bw, input logic [7:0] ba, input logic [7:0] bd,
                       input logic ea, input logic eb);
        a_valid = av; a_we = aw; a_addr = aa; a_wdata = ad;
        b_valid = bv; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge Clk);
        check("a_ready", a_ready, ea);
        check("b_ready", b_ready, eb);
        @(posedge Clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drv(0, 0, 8'h00, 8'h00, 0, 0, 8'h00, 8'h00, 0, 0);
    endtask

    initial begin
        logic [7:0] wdat[5];
        wdat[0] = 8'h00; wdat[1] = 8'h01; wdat[2] = 8'h10; wdat[3] = 8'h06; wdat[4] = 8'h12;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        ram_dataOut = 8'h00;

        // Reset held 3 cycles with both requesters asking
        Rst = 1'b1;
        a_valid = 1'b1; a_we = 1'b0; a_addr = 8'h00; a_wdata = 8'h00;
        b_valid = 1'b1; b_we = 1'b0; b_addr = 8'h00; b_wdata = 8'h00;
        @(posedge Clk);
        #1;
        mon_en = 1'b1;
        for (int i = 0; i < 2; i++) drv(1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 0);
        check("rst_ram_ctl", {ram_CS, ram_WE, ram_RD}, 0);
        check("rst_ram_addr", ram_Addr, 0);
        check("rst_ram_din", ram_dataIn, 0);
        check("rst_rvalid", {a_rvalid, b_rvalid}, 0);
        check("rst_rdata", {a_rdata, b_rdata}, 0);
        Rst = 1'b0;
        drv(1, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 1, 0);
        drv(0, 0, 8'h00, 8'h00, 1, 0, 8'h00, 8'h00, 0, 1);
        idle(2);

        // Single requester: back-to-back writes then reads
        for (int i = 0; i < 5; i++) drv(1, 1, 8'(i), wdat[i], 0, 0, 8'h00, 8'h00, 1, 0);
        for (int i = 0; i < 5; i++) drv(1, 0, 8'(i), 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        idle(3);

        // Contention: preload, then strict alternation starting at A
        drv(1, 1, 8'h10, 8'hAA, 0, 0, 8'h00, 8'h00, 1, 0);
        drv(0, 0, 8'h00, 8'h00, 1, 1, 8'h20, 8'hBB, 0, 1);
        for (int i = 0; i < 6; i++)
            drv(1, 0, 8'h10, 8'h00, 1, 0, 8'h20, 8'h00, (i % 2) == 0, (i % 2) == 1);
        idle(3);

        // Write-then-read hazard on the same address
        drv(0, 0, 8'h00, 8'h00, 1, 1, 8'h7F, 8'h5C, 0, 1);
        drv(1, 0, 8'h7F, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        idle(3);

        // Reset while a read is in flight: its return must be dropped
        drv(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        Rst = 1'b1;
        q.delete();
        idle(1);
        Rst = 1'b0;
        idle(3);
        drv(1, 0, 8'h03, 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
        idle(3);

        // Idle gaps: valid toggles every other cycle
        for (int i = 0; i < 5; i++) begin
            drv(1, 0, 8'(i), 8'h00, 0, 0, 8'h00, 8'h00, 1, 0);
            idle(1);
        end
        idle(3);

        check("scoreboard_empty", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
- Two-requester arbiter/sequencer in front of the existing syncRAM (8-bit data, 8-bit address, CS/WE/RD strobes, one clock).
- Accepts read/write commands from requesters A and B through valid/ready handshakes.
- Grants the single RAM port round-robin, drives registered RAM strobes, and routes read data back to the originating requester with fixed latency.
- Sits between client blocks (e.g. packet/lookup engines) and syncRAM; syncRAM is instantiated beside it, not inside.

Parameters:
- DATA_W, 8, RAM data width
- ADDR_W, 8, RAM address width

Ports:
- Clk  in  1  system clock, rising edge
- Rst  in  1  synchronous, active-high reset
- a_valid  in  1  requester A command valid
- a_ready  out  1  requester A command accepted this cycle
- a_we  in  1  1 = write, 0 = read
- a_addr  in  ADDR_W  requester A address
- a_wdata  in  DATA_W  requester A write data
- a_rvalid  out  1  requester A read data valid (single-cycle pulse)
- a_rdata  out  DATA_W  requester A read data
- b_valid, b_ready, b_we, b_addr, b_wdata, b_rvalid, b_rdata  same as A, for requester B
- ram_CS  out  1  to syncRAM CS
- ram_WE  out  1  to syncRAM WE
- ram_RD  out  1  to syncRAM RD
- ram_Addr  out  ADDR_W  to syncRAM Addr
- ram_dataIn  out  DATA_W  to syncRAM dataIn
- ram_dataOut  in  DATA_W  from syncRAM dataOut; valid the cycle after a CS&RD edge

Behaviour:
- Reset: ram_CS/WE/RD=0, ram_Addr=0, ram_dataIn=0, a/b_rvalid=0, a/b_rdata=0, priority pointer = A. In-flight reads are discarded; no rvalid is issued after Rst for commands accepted before it.
- Arbitration (cycle N, combinational):
  - only one valid: that requester gets ready=1.
  - both valid: the pointer holder gets ready=1, the other gets ready=0.
  - neither valid: no grant.
  - ready may depend on valid; at most one ready per cycle.
- Pointer update: after any grant, pointer moves to the non-granted requester. Both continuously valid gives strict A,B,A,B alternation. No starvation: worst-case wait is 1 cycle.
- Requesters hold valid and payload stable until ready. Dropping valid without ready is legal; no command is issued in that case.
- Issue (cycle N+1): granted command is registered onto ram_*.
  - ram_CS=1.
  - ram_WE=we, ram_RD=~we.
  - ram_Addr and ram_dataIn from the granted requester.
  - No grant in N: ram_CS/WE/RD=0; Addr/dataIn hold their last value.
- RAM samples at the rising edge ending N+1.
- Read return (cycle N+2): rvalid=1 for exactly one cycle to the originating requester only. rdata = ram_dataOut, registered or passed through with the same timing.
- Writes produce no response.
- Latency: read acceptance to rvalid is 2 cycles.
- Throughput: 1 command/cycle sustained.
- Response tracking: 2-deep shift of {valid, is_read, id}, so interleaved A/B reads return in issue order.
- Ordering/hazards: write accepted in N followed by a read to the same address in N+1 returns the new data. The write completes at the edge ending N+1, before the read edge ending N+2. No forwarding logic is needed.
- Simultaneous rvalid to both requesters is impossible.
- Rst asserted mid-burst: the next cycle shows all reset values and rvalid=0, even if a read was in the pipeline.
- Address and width: no wrap or translation; addresses pass through unchanged, full 0..2^ADDR_W-1 range.

Decomposition:
- Package sram_arb_pkg:
  - DATA_W/ADDR_W defaults.
  - Requester id constants REQ_A=0, REQ_B=1.
  - Command struct {we, addr, wdata}.
  - Response-tracking struct {vld, rd, id}.
- Sub-module rr_arbiter2: 2-way round-robin grant plus pointer register (Clk, Rst, req[1:0] -> gnt[1:0]).
- sram_arbiter holds the command mux, issue register, return pipeline and rdata routing.

Test Plan:
- Reset check: Rst=1 for 3 cycles with a_valid=b_valid=1 -> all ram_* and rvalid outputs 0, no ready; after release, first grant goes to A.
- Single requester write/read: A writes addr 0..4 with data 0x00, 0x01, 0x10, 0x06, 0x12 on consecutive cycles (ready=1 each cycle), then reads 0..4 -> a_rvalid 2 cycles after each read acceptance, a_rdata = 0x00, 0x01, 0x10, 0x06, 0x12; b_rvalid never set.
- Contention: A and B both valid for 6 cycles with reads of A:0x10, B:0x20 (preloaded 0xAA/0xBB) -> grants A,B,A,B,A,B; a_rvalid/b_rvalid alternate with 0xAA/0xBB; never both high.
- Back-to-back hazard: B writes 0x5C to addr 0x7F, A reads 0x7F the next cycle -> a_rdata=0x5C at read+2.
- Reset mid-operation: A reads addr 3 (holds 0x06); assert Rst the cycle after acceptance -> a_rvalid stays 0; post-reset read of addr 3 returns 0x06.
- Idle gaps: A issues reads with valid toggling every other cycle -> ram_CS pulses only on issue cycles; latency stays exactly 2.
